sauce_cracker: RTL and testbench

- Inverse of the flag-vending sauce path. Takes an observed 8-bit display byte on switches and un-XORs it with the sauce key to get the product.
- Then runs a sequential brute-force search over all 4-bit (a,b) pairs for the first pair with a*b equal to that product.
- Recovered pair is driven on Disp as {a,b}, with status flags. Sits beside the sauce block on the same board I/O: BTNL starts, switches carry data, Disp shows the result.

---
 rtl/sauce_cracker.sv | 118 +++++++++++
 tb/tb_sauce_cracker.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sauce_cracker.sv
// sauce_cracker: un-XORs the display byte, then brute-forces the first 4x4 (a,b) with a*b == target.
// Define SAUCE_COUNT_ALL_EN to sweep all 256 candidates and count every match on match_cnt.
module sauce_cracker #(
    parameter logic [7:0] XOR_KEY = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTNL,
    input  logic [7:0] switches,
    output logic [7:0] Disp,
    output logic       busy,
    output logic       found,
    output logic       none,
    output logic [8:0] match_cnt
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    state_t     state_q, state_d;
    logic       s1_q, s2_q, s3_q;
    logic [7:0] k_q, k_d, target_q, target_d, disp_q, disp_d;
    logic       found_q, found_d, none_q, none_d;
    logic [7:0] prod;
    logic       start, hit;
`ifdef SAUCE_COUNT_ALL_EN
    logic [8:0] cnt_q, cnt_d;
`endif
    assign start = s2_q & ~s3_q;
    // Zero-extend before multiplying so 15*15 keeps all 8 product bits.
    assign prod  = {4'd0, k_q[7:4]} * {4'd0, k_q[3:0]};
    assign hit   = prod == target_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            {s1_q, s2_q, s3_q} <= 3'b000;
            k_q      <= '0;
            target_q <= '0;
            disp_q   <= '0;
            found_q  <= 1'b0;
            none_q   <= 1'b0;
`ifdef SAUCE_COUNT_ALL_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            {s1_q, s2_q, s3_q} <= {BTNL, s1_q, s2_q};
            k_q      <= k_d;
            target_q <= target_d;
            disp_q   <= disp_d;
            found_q  <= found_d;
            none_q   <= none_d;
`ifdef SAUCE_COUNT_ALL_EN
            cnt_q    <= cnt_d;
`endif
        end
    end
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        target_d = target_q;
        disp_d   = disp_q;
        found_d  = found_q;
        none_d   = none_q;
`ifdef SAUCE_COUNT_ALL_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            SEARCH: begin
`ifdef SAUCE_COUNT_ALL_EN
                if (hit) begin
                    cnt_d = cnt_q + 9'd1;
                    if (!found_q) begin
                        disp_d  = k_q;
                        found_d = 1'b1;
                    end
                end
                if (k_q == 8'hFF) begin
                    state_d = DONE;
                    none_d  = !hit && cnt_q == 9'd0;
                end else begin
                    k_d = k_q + 8'd1;
                end
`else
                if (hit) begin
                    disp_d  = k_q;
                    found_d = 1'b1;
                    state_d = DONE;
                end else if (k_q == 8'hFF) begin
                    none_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 8'd1;
                end
`endif
            end
            default: begin
                if (start) begin
                    state_d  = SEARCH;
                    target_d = switches ^ XOR_KEY;
                    k_d      = '0;
                    disp_d   = '0;
                    found_d  = 1'b0;
                    none_d   = 1'b0;
`ifdef SAUCE_COUNT_ALL_EN
                    cnt_d    = '0;
`endif
                end
            end
        endcase
    end
    assign Disp  = disp_q;
    assign busy  = state_q == SEARCH;
    assign found = found_q;
    assign none  = none_q;
`ifdef SAUCE_COUNT_ALL_EN
    assign match_cnt = cnt_q;
`else
    assign match_cnt = 9'd0;
`endif
endmodule

// File: tb/tb_sauce_cracker.sv
// tb_sauce_cracker: directed checks of the sauce cracker search, flags, latency and mid-search events.
module tb_sauce_cracker;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       BTNL = 1'b0;
    logic [7:0] switches = 8'h00;
    logic [7:0] Disp;
    logic       busy, found, none;
    logic [8:0] match_cnt;
    int         tests = 0;
    int         fails = 0;
`ifdef SAUCE_COUNT_ALL_EN
    localparam bit CA = 1'b1;
`else
    localparam bit CA = 1'b0;
`endif

    sauce_cracker dut (
        .clk(clk), .rst(rst), .BTNL(BTNL), .switches(switches),
        .Disp(Disp), .busy(busy), .found(found), .none(none), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_busy(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = busy;
        end
        check({tag, "_start"}, 32'(ok), 32'd1);
    endtask

    task automatic count_search(output int n);
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] sw, input int cyc, input logic [7:0] d,
                       input logic f, input logic nn, input logic [8:0] mc);
        int n;
        BTNL = 1'b0;
        repeat (3) @(negedge clk);
        switches = sw;
        BTNL = 1'b1;
        wait_busy(tag);
        count_search(n);
        BTNL = 1'b0;
        check({tag, "_cycles"}, 32'(n), 32'(cyc));
        check({tag, "_disp"}, 32'(Disp), 32'(d));
        check({tag, "_found"}, 32'(found), 32'(f));
        check({tag, "_none"}, 32'(none), 32'(nn));
        check({tag, "_cnt"}, 32'(match_cnt), CA ? 32'(mc) : 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_disp", 32'(Disp), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {30'd0, found, none}, 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        run("t0",   8'h5A, CA ? 256 : 1,   8'h00, 1'b1, 1'b0, 9'd31);
        run("t12",  8'h56, CA ? 256 : 29,  8'h1C, 1'b1, 1'b0, 9'd6);
        run("t17",  8'h4B, 256,            8'h00, 1'b0, 1'b1, 9'd0);
        run("t225", 8'hBB, 256,            8'hFF, 1'b1, 1'b0, 9'd1);

        // a second press during SEARCH must not recapture the new switches
        repeat (3) @(negedge clk);
        switches = 8'h56;
        BTNL = 1'b1;
        wait_busy("ign");
        BTNL = 1'b0;
        repeat (3) @(negedge clk);
        switches = 8'h5A;
        BTNL = 1'b1;
        repeat (4) @(negedge clk);
        BTNL = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        count_search(n);
        check("ign_done", 32'(busy), 32'd0);
        check("ign_disp", 32'(Disp), 32'h1C);
        check("ign_found", 32'(found), 32'd1);

        // async reset at SEARCH cycle 10
        repeat (3) @(negedge clk);
        switches = 8'hBB;
        BTNL = 1'b1;
        wait_busy("rstm");
        repeat (9) @(negedge clk);
        check("rstm_busy_pre", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_disp", 32'(Disp), 32'd0);
        check("rstm_flags", {30'd0, found, none}, 32'd0);
        BTNL = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("rstm_idle", 32'(busy), 32'd0);
        check("rstm_idle_disp", 32'(Disp), 32'd0);

        // holding BTNL gives exactly one start
        switches = 8'h56;
        BTNL = 1'b1;
        wait_busy("hold");
        count_search(n);
        check("hold_cycles", 32'(n), CA ? 32'd256 : 32'd29);
        repeat (20) @(negedge clk);
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_disp", 32'(Disp), 32'h1C);
        run("again", 8'hBB, 256, 8'hFF, 1'b1, 1'b0, 9'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
